// File: rtl/facto_read_port.sv
// -----------------------------------------------------------------------------
// facto_read_port
//   Read side of the 7-slot factorial register file. A 3-bit slot address with
//   a read enable is decoded into a registered one-hot read strobe (stage 1).
//   The addressed slot is then taken from the flattened register-file bus and
//   returned through a registered data stage with a one-cycle valid pulse
//   (stage 2). Address 7 is invalid: it returns zero data flagged by addr_err.
//
// Configuration macro:
//   FACTO_READ_BYPASS_EN - when defined, adds wEn/din so that a write to the
//                          slot being read on the stage-2 edge is forwarded to
//                          dout. When undefined, dout always comes from
//                          reg_flat, so a same-edge write returns the old value.
//
// Ports:
//   clk        in   1           rising-edge clock
//   reset_n    in   1           asynchronous active-low reset
//   re         in   1           read request, sampled every rising edge
//   Addr       in   3           slot address 0..6 (7 is invalid)
//   reg_flat   in   NREG*WIDTH  slot k at bits [k*WIDTH +: WIDTH]
//   wEn        in   NREG        write decoder one-hot strobe (bypass build only)
//   din        in   WIDTH       write data (bypass build only)
//   rEn        out  NREG        registered one-hot read strobe (stage 1)
//   dout       out  WIDTH       read data (stage 2), held between reads
//   dout_valid out  1           one-cycle pulse when dout is updated
//   addr_err   out  1           one-cycle pulse with dout_valid when Addr was 7
// -----------------------------------------------------------------------------
module facto_read_port #(
  parameter int WIDTH = 64,
  parameter int NREG  = 7   // tied to the 3-bit address; do not override
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  re,
  input  logic [2:0]            Addr,
  input  logic [NREG*WIDTH-1:0] reg_flat,
`ifdef FACTO_READ_BYPASS_EN
  input  logic [NREG-1:0]       wEn,
  input  logic [WIDTH-1:0]      din,
`endif
  output logic [NREG-1:0]       rEn,
  output logic [WIDTH-1:0]      dout,
  output logic                  dout_valid,
  output logic                  addr_err
);

  localparam logic [2:0] ADDR_INVALID = 3'd7;

  // Stage-1 pipeline state: request valid and its captured slot address.
  logic       r_v1;
  logic [2:0] r_a1;

  logic [NREG-1:0]  w_ren_next;
  logic [WIDTH-1:0] w_rd_data;

  // One-hot decode of the incoming request; invalid address yields no strobe.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    w_ren_next = '0;
    for (int k = 0; k < NREG; k++) begin
      if (re && (Addr == k[2:0])) begin
        w_ren_next[k] = 1'b1;
      end
    end
  end

  // Slot select for stage 2. An invalid address matches no slot and reads 0.
  always_comb begin
    w_rd_data = '0;
    for (int k = 0; k < NREG; k++) begin
      if (r_a1 == k[2:0]) begin
`ifdef FACTO_READ_BYPASS_EN
        // Register file updates on this same edge; forward the incoming write.
        w_rd_data = wEn[k] ? din : reg_flat[k*WIDTH +: WIDTH];
`else
        w_rd_data = reg_flat[k*WIDTH +: WIDTH];
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rEn        <= '0;
      r_v1       <= 1'b0;
      r_a1       <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      addr_err   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments let stage 2 see the stage-1 values from
      // before this edge, which is what makes the two stages a real pipeline.
      rEn  <= w_ren_next;
      r_v1 <= re;
      if (re) begin
        r_a1 <= Addr;
      end

      dout_valid <= r_v1;
      addr_err   <= r_v1 && (r_a1 == ADDR_INVALID);
      if (r_v1) begin
        dout <= w_rd_data;
      end
    end
  end

endmodule

// File: tb/tb_facto_read_port.sv
// -----------------------------------------------------------------------------
// tb_facto_read_port
//   Self-checking bench for facto_read_port. A behavioural model holds the
//   register-file contents in an array and the requests in flight in a queue;
//   each clock it predicts strobe, data, valid and error from those.
// -----------------------------------------------------------------------------
module tb_facto_read_port;

  localparam int W = 64;
  localparam int N = 7;

  logic           clk = 1'b0;
  logic           reset_n;
  logic           tb_re;
  logic [2:0]     tb_addr;
  logic [N*W-1:0] reg_flat;
  logic [N-1:0]   rEn;
  logic [W-1:0]   dout;
  logic           dout_valid;
  logic           addr_err;
`ifdef FACTO_READ_BYPASS_EN
  logic [N-1:0]   tb_wen;
  logic [W-1:0]   tb_din;
`endif

  // Register-file contents as seen by the read port.
  logic [W-1:0] slots [N];

  // Model state: request captured last edge (-1 = none) and predicted outputs.
  int           pend_q [$];
  logic [N-1:0] exp_ren;
  logic [W-1:0] exp_dout;
  logic         exp_valid;
  logic         exp_err;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  always_comb begin
    for (int k = 0; k < N; k++) reg_flat[k*W +: W] = slots[k];
  end

  facto_read_port #(.WIDTH(W), .NREG(N)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .re         (tb_re),
    .Addr       (tb_addr),
    .reg_flat   (reg_flat),
`ifdef FACTO_READ_BYPASS_EN
    .wEn        (tb_wen),
    .din        (tb_din),
`endif
    .rEn        (rEn),
    .dout       (dout),
    .dout_valid (dout_valid),
    .addr_err   (addr_err)
  );

  task automatic model_reset();
    pend_q    = {-1};
    exp_ren   = '0;
    exp_dout  = '0;
    exp_valid = 1'b0;
    exp_err   = 1'b0;
  endtask

  // Predict the outcome of the coming edge from current inputs, then advance
  // to 1 time unit after that edge, where outputs are sampled and inputs
  // changed.
  task automatic tick();
    int a;
    a = pend_q.pop_front();
    if (a >= 0) begin
      exp_valid = 1'b1;
      exp_err   = (a == 7);
      if (a == 7) exp_dout = '0;
      else begin
        exp_dout = slots[a];
`ifdef FACTO_READ_BYPASS_EN
        if (tb_wen[a]) exp_dout = tb_din;
`endif
      end
    end else begin
      exp_valid = 1'b0;
      exp_err   = 1'b0;
    end
    exp_ren = (tb_re && tb_addr != 3'd7) ? (N'(1) << tb_addr) : '0;
    pend_q.push_back(tb_re ? int'(tb_addr) : -1);
    @(posedge clk);
    #1;
  endtask

  task automatic preload();
    for (int k = 0; k < N; k++) slots[k] = W'(64'h1000 + k);
  endtask

  task automatic test_reset();
    // Hold reset over two edges: everything must read 0.
    reset_n = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++;
    if ({rEn, dout, dout_valid, addr_err} !== '0) begin
      failures++;
      $display("FAIL reset_idle: rEn=%b dout=%h valid=%b err=%b, all required 0",
               rEn, dout, dout_valid, addr_err);
    end
    reset_n = 1'b1;
    model_reset();

    // Request slot 3, then assert reset before its data stage.
    tb_re = 1'b1; tb_addr = 3'd3;
    tick();
    checks++;
    if (rEn !== 7'b0001000) begin
      failures++;
      $display("FAIL reset_pre_strobe: rEn=%b required 0001000", rEn);
    end
    tb_re   = 1'b0;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({rEn, dout, dout_valid, addr_err} !== '0) begin
      failures++;
      $display("FAIL reset_async: rEn=%b dout=%h valid=%b err=%b, all required 0",
               rEn, dout, dout_valid, addr_err);
    end
    @(posedge clk); #1;
    reset_n = 1'b1;
    model_reset();
    tick();
    checks++;
    if (dout_valid !== 1'b0 || dout !== '0) begin
      failures++;
      $display("FAIL reset_drop: valid=%b dout=%h required valid 0 dout 0",
               dout_valid, dout);
    end
  endtask

  task automatic test_single_read();
    preload();
    tb_re = 1'b1; tb_addr = 3'd4;
    tick();
    checks++;
    if (rEn !== 7'b0010000 || dout_valid !== 1'b0) begin
      failures++;
      $display("FAIL single_stage1: rEn=%b valid=%b required 0010000 / 0", rEn, dout_valid);
    end
    tb_re = 1'b0;
    tick();
    checks++;
    if (dout !== 64'h1004 || dout_valid !== 1'b1 || addr_err !== 1'b0 || rEn !== '0) begin
      failures++;
      $display("FAIL single_data: dout=%h valid=%b err=%b rEn=%b required 1004/1/0/0",
               dout, dout_valid, addr_err, rEn);
    end
    tick();
    checks++;
    if (dout !== 64'h1004 || dout_valid !== 1'b0) begin
      failures++;
      $display("FAIL single_hold: dout=%h valid=%b required 1004/0", dout, dout_valid);
    end
  endtask

  task automatic test_back_to_back();
    int n_valid = 0;
    preload();
    for (int i = 0; i <= N; i++) begin
      tb_re   = (i < N);
      tb_addr = 3'(i % N);
      tick();
      if (dout_valid === 1'b1) n_valid++;
      if (i > 0) begin
        checks++;
        if (dout !== W'(64'h1000 + i - 1) || dout_valid !== 1'b1) begin
          failures++;
          $display("FAIL b2b_data[%0d]: dout=%h valid=%b required %h/1",
                   i - 1, dout, dout_valid, W'(64'h1000 + i - 1));
        end
      end
      if (i < N) begin
        checks++;
        if (rEn !== exp_ren || $countones(rEn) != 1) begin
          failures++;
          $display("FAIL b2b_strobe[%0d]: rEn=%b required %b", i, rEn, exp_ren);
        end
      end
    end
    tb_re = 1'b0;
    tick();
    checks++;
    if (n_valid != N || dout_valid !== 1'b0) begin
      failures++;
      $display("FAIL b2b_count: valid cycles=%0d trailing valid=%b required %0d/0",
               n_valid, dout_valid, N);
    end
  endtask

  task automatic test_addr_err();
    tb_re = 1'b1; tb_addr = 3'd7;
    tick();
    checks++;
    if (rEn !== '0) begin
      failures++;
      $display("FAIL err_strobe: rEn=%b required 0", rEn);
    end
    tb_re = 1'b0;
    tick();
    checks++;
    if (dout !== '0 || dout_valid !== 1'b1 || addr_err !== 1'b1) begin
      failures++;
      $display("FAIL err_data: dout=%h valid=%b err=%b required 0/1/1",
               dout, dout_valid, addr_err);
    end
    tick();
    checks++;
    if (dout_valid !== 1'b0 || addr_err !== 1'b0) begin
      failures++;
      $display("FAIL err_pulse: valid=%b err=%b required 0/0", dout_valid, addr_err);
    end
  endtask

  task automatic test_same_cycle_write();
    logic [W-1:0] want;
    slots[2] = W'(64'd120);
    tb_re = 1'b1; tb_addr = 3'd2;
    tick();
    tb_re = 1'b0;
`ifdef FACTO_READ_BYPASS_EN
    tb_wen = 7'b0000100; tb_din = W'(64'd720);
    want   = W'(64'd720);
`else
    want   = W'(64'd120);
`endif
    tick();
    // Register file takes the write on that same edge.
    slots[2] = W'(64'd720);
`ifdef FACTO_READ_BYPASS_EN
    tb_wen = '0;
`endif
    checks++;
    if (dout !== want || dout_valid !== 1'b1 || dout !== exp_dout) begin
      failures++;
      $display("FAIL same_cycle_write: dout=%0d valid=%b required %0d/1",
               dout, dout_valid, want);
    end
  endtask

  task automatic test_idle_hold();
    preload();
    tb_re = 1'b1; tb_addr = 3'd5;
    tick();
    tb_re = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      tb_addr = 3'($urandom_range(0, 7));
      tick();
      checks++;
      if (dout_valid !== 1'b0 || addr_err !== 1'b0 || rEn !== '0 || dout !== 64'h1005) begin
        failures++;
        $display("FAIL idle[%0d]: valid=%b err=%b rEn=%b dout=%h required 0/0/0/1005",
                 i, dout_valid, addr_err, rEn, dout);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      tb_re   = 1'($urandom_range(0, 1));
      tb_addr = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) == 0) slots[$urandom_range(0, N - 1)] = {$urandom, $urandom};
`ifdef FACTO_READ_BYPASS_EN
      tb_wen = ($urandom_range(0, 2) == 0) ? (N'(1) << $urandom_range(0, N - 1)) : '0;
      tb_din = {$urandom, $urandom};
`endif
      tick();
      checks++;
      if (rEn !== exp_ren || dout !== exp_dout || dout_valid !== exp_valid || addr_err !== exp_err) begin
        failures++;
        $display("FAIL random[%0d]: rEn=%b dout=%h valid=%b err=%b required %b/%h/%b/%b",
                 i, rEn, dout, dout_valid, addr_err, exp_ren, exp_dout, exp_valid, exp_err);
      end
    end
  endtask

  initial begin
    reset_n = 1'b0;
    tb_re   = 1'b0;
    tb_addr = '0;
`ifdef FACTO_READ_BYPASS_EN
    tb_wen  = '0;
    tb_din  = '0;
`endif
    for (int k = 0; k < N; k++) slots[k] = '0;
    model_reset();

    test_reset();
    test_single_read();
    test_back_to_back();
    test_addr_err();
    test_same_cycle_write();
    test_idle_hold();
    test_random();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
